mat_store: RTL and testbench

- Two-slot matrix storage that sits directly upstream of the matrix multiplier.
- Accepts a matrix as a row-major element stream into slot 0 or slot 1 and records its dimensions and a per-slot valid flag.
- Serves the multiplier's element read port, which drives rd_en, slot, row, col and current m/n, and returns rd_elem / rd_elem_valid.

---
 rtl/mat_store_if.sv | 44 ++++
 rtl/mat_store.sv | 117 +++++++++++
 tb/tb_mat_store.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mat_store_if.sv
// mat_store_if: write-stream and element-read bundle between loader, mat_store and multiplier
interface mat_store_if #(
  parameter int DIM_WIDTH  = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_start;
  logic                  wr_slot;
  logic [DIM_WIDTH-1:0]  wr_m;
  logic [DIM_WIDTH-1:0]  wr_n;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_elem;
  logic                  wr_ready;
  logic                  wr_done;
  logic                  wr_error;
  logic                  slot0_valid;
  logic                  slot1_valid;
  logic [DIM_WIDTH-1:0]  slot0_m;
  logic [DIM_WIDTH-1:0]  slot0_n;
  logic [DIM_WIDTH-1:0]  slot1_m;
  logic [DIM_WIDTH-1:0]  slot1_n;
  logic                  rd_en;
  logic                  rd_slot_idx;
  logic [DIM_WIDTH-1:0]  rd_row_idx;
  logic [DIM_WIDTH-1:0]  rd_col_idx;
  logic [DIM_WIDTH-1:0]  rd_current_m;
  logic [DIM_WIDTH-1:0]  rd_current_n;
  logic [DATA_WIDTH-1:0] rd_elem;
  logic                  rd_elem_valid;
  logic                  rd_oob;
  modport master (
    output wr_start, wr_slot, wr_m, wr_n, wr_valid, wr_elem,
    output rd_en, rd_slot_idx, rd_row_idx, rd_col_idx, rd_current_m, rd_current_n,
    input  wr_ready, wr_done, wr_error,
    input  slot0_valid, slot1_valid, slot0_m, slot0_n, slot1_m, slot1_n,
    input  rd_elem, rd_elem_valid, rd_oob
  );
  modport slave (
    input  wr_start, wr_slot, wr_m, wr_n, wr_valid, wr_elem,
    input  rd_en, rd_slot_idx, rd_row_idx, rd_col_idx, rd_current_m, rd_current_n,
    output wr_ready, wr_done, wr_error,
    output slot0_valid, slot1_valid, slot0_m, slot0_n, slot1_m, slot1_n,
    output rd_elem, rd_elem_valid, rd_oob
  );
endinterface

// File: rtl/mat_store.sv
// mat_store: two-slot row-major matrix buffer with a 1-cycle element read port
module mat_store #(
  parameter int DIM_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 5
) (
  input logic        clk,
  input logic        rst,
  mat_store_if.slave bus
);
  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = 2 * DIM_WIDTH;
  localparam logic [DIM_WIDTH-1:0] MAXD = DIM_WIDTH'(MAX_DIM);
  typedef enum logic {W_IDLE, W_FILL} w_state_t;
  w_state_t              r_state, w_next;
  logic                  r_slot;
  logic [LW-1:0]         r_total, r_cnt;
  logic [DIM_WIDTH-1:0]  r_wm, r_wn;
  logic                  r_vld [2];
  logic [DIM_WIDTH-1:0]  r_m [2];
  logic [DIM_WIDTH-1:0]  r_n [2];
  logic [DATA_WIDTH-1:0] r_mem [2][DEPTH];
  logic                  r_done, r_error;
  logic [DATA_WIDTH-1:0] r_rd_elem;
  logic                  r_rd_valid, r_rd_oob;
  logic                  w_legal, w_start_ok, w_beat, w_last, w_rd_oob;
  logic [LW-1:0]         w_lin;
  assign w_legal    = bus.wr_m != '0 && bus.wr_m <= MAXD && bus.wr_n != '0 && bus.wr_n <= MAXD;
  assign w_start_ok = r_state == W_IDLE && bus.wr_start && w_legal;
  assign w_beat     = r_state == W_FILL && bus.wr_valid;
  assign w_last     = w_beat && r_cnt == r_total - LW'(1);
  assign w_rd_oob   = bus.rd_row_idx >= bus.rd_current_m || bus.rd_col_idx >= bus.rd_current_n ||
                      bus.rd_current_m == '0 || bus.rd_current_m > MAXD ||
                      bus.rd_current_n == '0 || bus.rd_current_n > MAXD;
  assign w_lin      = LW'(bus.rd_row_idx) * LW'(bus.rd_current_n) + LW'(bus.rd_col_idx);
  // write FSM next state: enter fill on a legal start, leave on the final beat
  always_comb begin
    w_next = r_state;
    if (w_start_ok) w_next = W_FILL;
    else if (w_last) w_next = W_IDLE;
  end
  // write FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= W_IDLE;
    else r_state <= w_next;
  end
  // load bookkeeping: latched geometry, beat counter, slot flags/dims, status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot  <= 1'b0;
      r_total <= '0;
      r_cnt   <= '0;
      r_wm    <= '0;
      r_wn    <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        r_vld[s] <= 1'b0;
        r_m[s]   <= '0;
        r_n[s]   <= '0;
      end
    end else begin
      r_done  <= w_last;
      r_error <= r_state == W_IDLE && bus.wr_start && !w_legal;
      if (w_start_ok) begin
        r_slot             <= bus.wr_slot;
        r_wm               <= bus.wr_m;
        r_wn               <= bus.wr_n;
        r_total            <= LW'(bus.wr_m) * LW'(bus.wr_n);
        r_cnt              <= '0;
        r_vld[bus.wr_slot] <= 1'b0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + LW'(1);
        if (w_last) begin
          r_vld[r_slot] <= 1'b1;
          r_m[r_slot]   <= r_wm;
          r_n[r_slot]   <= r_wn;
        end
      end
    end
  end
  // element storage; same-slot reads see the pre-write value since both sample before the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < DEPTH; i++)
          r_mem[s][i] <= '0;
    end else if (w_beat) r_mem[r_slot][r_cnt[AW-1:0]] <= bus.wr_elem;
  end
  // read port: always answers a request next cycle, zero data when out of range
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_elem  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_elem <= w_rd_oob ? '0 : r_mem[bus.rd_slot_idx][w_lin[AW-1:0]];
        r_rd_oob  <= w_rd_oob;
      end
    end
  end
  assign bus.wr_ready      = r_state == W_FILL;
  assign bus.wr_done       = r_done;
  assign bus.wr_error      = r_error;
  assign bus.slot0_valid   = r_vld[0];
  assign bus.slot1_valid   = r_vld[1];
  assign bus.slot0_m       = r_m[0];
  assign bus.slot0_n       = r_n[0];
  assign bus.slot1_m       = r_m[1];
  assign bus.slot1_n       = r_n[1];
  assign bus.rd_elem       = r_rd_elem;
  assign bus.rd_elem_valid = r_rd_valid;
  assign bus.rd_oob        = r_rd_oob;
endmodule

// File: tb/tb_mat_store.sv
// tb_mat_store: directed vectors and hand-written sequences for mat_store
module tb_mat_store;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  mat_store_if #(.DIM_WIDTH(3), .DATA_WIDTH(8)) bus ();
  mat_store #(.DIM_WIDTH(3), .DATA_WIDTH(8), .MAX_DIM(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       s;
    logic [2:0] r, c, m, n;
    logic [7:0] e;
    logic       o;
  } rv_t;
  rv_t tv [11];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic set_rd(input logic en, input logic s, input logic [2:0] r, c, m, n);
    bus.rd_en        = en;
    bus.rd_slot_idx  = s;
    bus.rd_row_idx   = r;
    bus.rd_col_idx   = c;
    bus.rd_current_m = m;
    bus.rd_current_n = n;
  endtask
  task automatic load(input logic s, input logic [2:0] m, n, input logic [7:0] base, step,
                      output int ready_cnt, output int done_cnt);
    ready_cnt = 0;
    done_cnt  = 0;
    @(negedge clk);
    bus.wr_start = 1'b1;
    bus.wr_slot  = s;
    bus.wr_m     = m;
    bus.wr_n     = n;
    @(negedge clk);
    bus.wr_start = 1'b0;
    for (int i = 0; i < int'(m) * int'(n); i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_elem  = base + 8'(i) * step;
      ready_cnt += int'(bus.wr_ready);
      @(negedge clk);
      done_cnt += int'(bus.wr_done);
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    done_cnt += int'(bus.wr_done);
    ready_cnt += int'(bus.wr_ready);
  endtask
  task automatic bad_start(input string name, input logic [2:0] m, n);
    @(negedge clk);
    bus.wr_start = 1'b1;
    bus.wr_slot  = 1'b1;
    bus.wr_m     = m;
    bus.wr_n     = n;
    @(negedge clk);
    bus.wr_start = 1'b0;
    chk({name, " wr_error"}, int'(bus.wr_error), 1);
    chk({name, " wr_ready"}, int'(bus.wr_ready), 0);
    @(negedge clk);
    chk({name, " wr_error clear"}, int'(bus.wr_error), 0);
  endtask
  initial begin
    int rc, dc;
    bus.wr_start = 1'b0; bus.wr_slot = 1'b0; bus.wr_m = '0; bus.wr_n = '0;
    bus.wr_valid = 1'b0; bus.wr_elem = '0;
    set_rd(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    tv[0]  = '{1'b0, 3'd1, 3'd2, 3'd2, 3'd3, 8'd6,  1'b0};
    tv[1]  = '{1'b0, 3'd0, 3'd0, 3'd2, 3'd3, 8'd1,  1'b0};
    tv[2]  = '{1'b0, 3'd1, 3'd0, 3'd2, 3'd3, 8'd4,  1'b0};
    tv[3]  = '{1'b0, 3'd2, 3'd0, 3'd2, 3'd3, 8'd0,  1'b1};
    tv[4]  = '{1'b0, 3'd0, 3'd3, 3'd2, 3'd3, 8'd0,  1'b1};
    tv[5]  = '{1'b0, 3'd0, 3'd0, 3'd0, 3'd3, 8'd0,  1'b1};
    tv[6]  = '{1'b0, 3'd0, 3'd0, 3'd2, 3'd6, 8'd0,  1'b1};
    tv[7]  = '{1'b1, 3'd1, 3'd1, 3'd2, 3'd2, 8'd40, 1'b0};
    tv[8]  = '{1'b1, 3'd0, 3'd1, 3'd2, 3'd2, 8'd20, 1'b0};
    tv[9]  = '{1'b0, 3'd1, 3'd1, 3'd2, 3'd2, 8'd4,  1'b0};
    tv[10] = '{1'b0, 3'd0, 3'd2, 3'd2, 3'd3, 8'd3,  1'b0};
    repeat (2) @(negedge clk);
    chk("reset wr_ready", int'(bus.wr_ready), 0);
    chk("reset slot0_valid", int'(bus.slot0_valid), 0);
    chk("reset rd_elem_valid", int'(bus.rd_elem_valid), 0);
    chk("reset rd_oob", int'(bus.rd_oob), 0);
    chk("reset wr_done", int'(bus.wr_done), 0);
    rst = 1'b0;
    load(1'b0, 3'd2, 3'd3, 8'd1, 8'd1, rc, dc);
    chk("load0 ready beats", rc, 6);
    chk("load0 done pulses", dc, 1);
    chk("load0 slot0_valid", int'(bus.slot0_valid), 1);
    chk("load0 slot0_m", int'(bus.slot0_m), 2);
    chk("load0 slot0_n", int'(bus.slot0_n), 3);
    load(1'b1, 3'd2, 3'd2, 8'd10, 8'd10, rc, dc);
    chk("load1 done pulses", dc, 1);
    chk("load1 slot1_valid", int'(bus.slot1_valid), 1);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_rd(1'b1, tv[i].s, tv[i].r, tv[i].c, tv[i].m, tv[i].n);
      @(negedge clk);
      set_rd(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
      chk($sformatf("vec%0d rd_elem", i), int'(bus.rd_elem), int'(tv[i].e));
      chk($sformatf("vec%0d rd_elem_valid", i), int'(bus.rd_elem_valid), 1);
      chk($sformatf("vec%0d rd_oob", i), int'(bus.rd_oob), int'(tv[i].o));
    end
    @(negedge clk);
    set_rd(1'b1, 1'b0, 3'd1, 3'd2, 3'd2, 3'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("held%0d valid", k), int'(bus.rd_elem_valid), 1);
      chk($sformatf("held%0d elem", k), int'(bus.rd_elem), 6);
      chk($sformatf("held%0d oob", k), int'(bus.rd_oob), 0);
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("held release valid", int'(bus.rd_elem_valid), 0);
    chk("held release elem hold", int'(bus.rd_elem), 6);
    bad_start("m6", 3'd6, 3'd2);
    bad_start("n0", 3'd2, 3'd0);
    chk("bad slot1_valid", int'(bus.slot1_valid), 1);
    chk("bad slot1_m", int'(bus.slot1_m), 2);
    chk("bad slot1_n", int'(bus.slot1_n), 2);
    set_rd(1'b1, 1'b1, 3'd1, 3'd1, 3'd2, 3'd2);
    @(negedge clk);
    chk("bad slot1 data", int'(bus.rd_elem), 40);
    bus.wr_start = 1'b1; bus.wr_slot = 1'b0; bus.wr_m = 3'd1; bus.wr_n = 3'd1;
    set_rd(1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 3'd2);
    @(negedge clk);
    chk("1x1 slot0_valid drop", int'(bus.slot0_valid), 0);
    chk("1x1 wr_ready", int'(bus.wr_ready), 1);
    chk("1x1 rd s1(0,0)", int'(bus.rd_elem), 10);
    bus.wr_start = 1'b0;
    set_rd(1'b1, 1'b1, 3'd1, 3'd1, 3'd2, 3'd2);
    @(negedge clk);
    chk("1x1 gap ready", int'(bus.wr_ready), 1);
    chk("1x1 gap slot0_valid", int'(bus.slot0_valid), 0);
    chk("1x1 rd s1(1,1)", int'(bus.rd_elem), 40);
    bus.wr_valid = 1'b1; bus.wr_elem = 8'd9;
    set_rd(1'b1, 1'b1, 3'd0, 3'd1, 3'd2, 3'd2);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk("1x1 slot0_valid rise", int'(bus.slot0_valid), 1);
    chk("1x1 wr_done", int'(bus.wr_done), 1);
    chk("1x1 wr_ready low", int'(bus.wr_ready), 0);
    chk("1x1 slot0_m", int'(bus.slot0_m), 1);
    chk("1x1 rd s1(0,1)", int'(bus.rd_elem), 20);
    chk("1x1 rd valid", int'(bus.rd_elem_valid), 1);
    set_rd(1'b1, 1'b0, 3'd0, 3'd0, 3'd1, 3'd1);
    @(negedge clk);
    chk("1x1 wr_done clear", int'(bus.wr_done), 0);
    chk("1x1 rd s0 value", int'(bus.rd_elem), 9);
    bus.rd_en = 1'b0;
    bus.wr_start = 1'b1; bus.wr_slot = 1'b0; bus.wr_m = 3'd2; bus.wr_n = 3'd3;
    @(negedge clk);
    bus.wr_start = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_elem = 8'd7;
    set_rd(1'b1, 1'b0, 3'd0, 3'd0, 3'd2, 3'd3);
    @(negedge clk);
    chk("rbw old value", int'(bus.rd_elem), 9);
    bus.wr_elem = 8'd8;
    bus.rd_en = 1'b0;
    @(negedge clk);
    bus.wr_elem = 8'd9;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk("midload ready", int'(bus.wr_ready), 1);
    #2 rst = 1'b1;
    #1;
    chk("async wr_ready", int'(bus.wr_ready), 0);
    chk("async slot0_valid", int'(bus.slot0_valid), 0);
    chk("async slot1_valid", int'(bus.slot1_valid), 0);
    chk("async slot1_m", int'(bus.slot1_m), 0);
    chk("async rd_elem", int'(bus.rd_elem), 0);
    @(negedge clk);
    rst = 1'b0;
    set_rd(1'b1, 1'b0, 3'd0, 3'd0, 3'd2, 3'd3);
    @(negedge clk);
    chk("post-reset s0 data", int'(bus.rd_elem), 0);
    chk("post-reset s0 valid rd", int'(bus.rd_elem_valid), 1);
    chk("post-reset slot0_valid", int'(bus.slot0_valid), 0);
    set_rd(1'b1, 1'b1, 3'd1, 3'd1, 3'd2, 3'd2);
    @(negedge clk);
    chk("post-reset s1 data", int'(bus.rd_elem), 0);
    bus.rd_en = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
